// File: rtl/audio_voice_sequencer.sv
// rtl/audio_voice_sequencer.sv - per-sample voice scheduler with saturating mixer
//
// Purpose:
//   On every rising edge of sample_clock, requests NUM_VOICES voices one after
//   another from a shared synthesis datapath, sums the returned signed samples
//   and publishes one saturated mix per sample period. Sticky flags report a
//   tick arriving while busy (overrun) and a voice that never answered (timeout).
//
// Optional feature macro: VOICE_MUTE_EN
//   Defined   - adds mute_mask; muted voices are skipped without a request.
//   Undefined - every voice is requested.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   sample_clock        sample-rate square wave, synchronous to clk
//   voice_sel           index of the voice being serviced
//   voice_req           one-cycle request for voice_sel
//   voice_sample        signed sample returned by the datapath
//   voice_valid         voice_sample valid (accepted only while waiting)
//   mix_out             saturated mix, held between updates
//   mix_valid           one-cycle pulse when mix_out updates
//   overrun, timeout    sticky error flags
//   err_clr             clears both sticky flags
//   mute_mask           (VOICE_MUTE_EN) per-voice mute, latched at the tick

module audio_voice_sequencer #(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 3,
  parameter int SAMPLE_W   = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clock,
  output logic [VOICE_W-1:0]    voice_sel,
  output logic                  voice_req,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  input  logic                  voice_valid,
  output logic [SAMPLE_W-1:0]   mix_out,
  output logic                  mix_valid,
  output logic                  overrun,
  output logic                  timeout,
`ifdef VOICE_MUTE_EN
  input  logic [NUM_VOICES-1:0] mute_mask,
`endif
  input  logic                  err_clr
);

  // Accumulator carries VOICE_W guard bits so summing NUM_VOICES full-scale
  // samples can never wrap before the final clamp.
  localparam int ACC_W = SAMPLE_W + VOICE_W;
  localparam logic [VOICE_W-1:0]      LAST_SEL = VOICE_W'(NUM_VOICES - 1);
  localparam logic [7:0]              CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_sc_q;
  logic [VOICE_W-1:0]      r_voice_sel, w_sel_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic [SAMPLE_W-1:0]     r_mix_out;
  logic                    r_mix_valid;
  logic                    r_overrun;
  logic                    r_timeout;

  logic                    w_tick;
  logic                    w_muted;
  logic                    w_advance;
  logic                    w_timeout_set;
  logic                    w_mix_load;
  logic signed [ACC_W-1:0] w_sample_ext;
  logic [SAMPLE_W-1:0]     w_clamped;

  // sc_q resets high so a sample_clock already high at reset release is not a tick.
  assign w_tick       = sample_clock & ~r_sc_q;
  assign w_sample_ext = ACC_W'($signed(voice_sample));

`ifdef VOICE_MUTE_EN
  logic [NUM_VOICES-1:0] r_mute;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mute <= '0;
    end else if (r_state == S_IDLE && w_tick) begin
      r_mute <= mute_mask;
    end
  end

  assign w_muted = r_mute[r_voice_sel];
`else
  assign w_muted = 1'b0;
`endif

  always_comb begin
    w_clamped = r_acc[SAMPLE_W-1:0];
    if (r_acc > SAT_MAX) begin
      w_clamped = SAT_MAX[SAMPLE_W-1:0];
    end else if (r_acc < SAT_MIN) begin
      w_clamped = SAT_MIN[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_voice_sel;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_advance     = 1'b0;
    w_timeout_set = 1'b0;
    w_mix_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_acc_nxt   = '0;
          w_sel_nxt   = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt = '0;
        // A muted voice burns this single cycle and contributes nothing.
        if (w_muted) begin
          w_advance = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (voice_valid) begin
          w_acc_nxt = r_acc + w_sample_ext;
          w_advance = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_set = 1'b1;
          w_advance     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_mix_load  = 1'b1;
        w_sel_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_advance) begin
      if (r_voice_sel == LAST_SEL) begin
        w_state_nxt = S_DONE;
      end else begin
        w_sel_nxt   = r_voice_sel + VOICE_W'(1);
        w_state_nxt = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc_q      <= 1'b1;
      r_voice_sel <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_sc_q      <= sample_clock;
      r_voice_sel <= w_sel_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mix_valid <= w_mix_load;
      if (w_mix_load) begin
        r_mix_out <= w_clamped;
      end
      // Setting takes priority over a simultaneous clear.
      if (w_tick && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end else if (err_clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign voice_sel = r_voice_sel;
  assign voice_req = (r_state == S_ISSUE) & ~w_muted;
  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;
  assign overrun   = r_overrun;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_audio_voice_sequencer.sv
// tb/tb_audio_voice_sequencer.sv - directed self-checking bench for audio_voice_sequencer

module tb_audio_voice_sequencer;

  localparam int NV = 8;
  localparam int VW = 3;
  localparam int SW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_clock = 1'b1;
  logic          voice_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic [SW-1:0] voice_sample = '0;
  logic [VW-1:0] voice_sel;
  logic          voice_req;
  logic [SW-1:0] mix_out;
  logic          mix_valid;
  logic          overrun;
  logic          timeout;
`ifdef VOICE_MUTE_EN
  logic [NV-1:0] mute_mask = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cyc = 0;
  int mix_cyc  = 0;
  int mix_cnt  = 0;

  logic [SW-1:0] rsp_val   [NV];
  int            rsp_delay [NV];
  bit            rsp_stall [NV];
  bit            rsp_pend = 1'b0;
  int            rsp_left = 0;
  int            rsp_sel  = 0;
  int            req_log [$];

  always #5 clk = ~clk;

  audio_voice_sequencer #(
    .NUM_VOICES(NV), .VOICE_W(VW), .SAMPLE_W(SW), .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_clock (sample_clock),
    .voice_sel    (voice_sel),
    .voice_req    (voice_req),
    .voice_sample (voice_sample),
    .voice_valid  (voice_valid),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .overrun      (overrun),
    .timeout      (timeout),
`ifdef VOICE_MUTE_EN
    .mute_mask    (mute_mask),
`endif
    .err_clr      (err_clr)
  );

  // Synth datapath model plus monitor: answers each request rsp_delay cycles
  // after the cycle following voice_req, logs requests and mix pulses.
  always @(posedge clk) begin
    cyc++;
    #1;
    voice_valid = 1'b0;
    if (rsp_pend) begin
      if (rsp_left == 0) begin
        voice_valid  = 1'b1;
        voice_sample = rsp_val[rsp_sel];
        rsp_pend     = 1'b0;
      end else begin
        rsp_left--;
      end
    end
    if (voice_req) begin
      req_log.push_back(int'(voice_sel));
      if (!rsp_stall[voice_sel]) begin
        rsp_pend = 1'b1;
        rsp_sel  = int'(voice_sel);
        rsp_left = rsp_delay[voice_sel];
      end
    end
    if (mix_valid) begin
      mix_cnt++;
      mix_cyc = cyc;
    end
  end

  task automatic set_all(input logic [SW-1:0] v);
    for (int i = 0; i < NV; i++) begin
      rsp_val[i]   = v;
      rsp_delay[i] = 0;
      rsp_stall[i] = 1'b0;
    end
  endtask

  task automatic start_frame();
    req_log.delete();
    @(negedge clk);
    sample_clock = 1'b1;
    tick_cyc = cyc + 1;
  endtask

  task automatic wait_mix(input int budget, output bit got);
    int start;
    start = mix_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (mix_cnt != start) got = 1'b1;
    end
  endtask

  task automatic run_frame(output bit got);
    start_frame();
    repeat (3) @(negedge clk);
    sample_clock = 1'b0;
    wait_mix(400, got);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    #2 rst = 1'b1;
    sample_clock = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (voice_sel !== 3'd0) begin n_fail++; $display("FAIL reset_voice_sel: got %0d required 0", voice_sel); end
    n_checks++; if (voice_req !== 1'b0) begin n_fail++; $display("FAIL reset_voice_req: got %b required 0", voice_req); end
    n_checks++; if (mix_out !== 16'h0000) begin n_fail++; $display("FAIL reset_mix_out: got %h required 0000", mix_out); end
    n_checks++; if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mix_valid: got %b required 0", mix_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b required 0", timeout); end
    @(negedge clk);
    rst = 1'b0;
    req_log.delete();
    base = mix_cnt;
    repeat (8) @(negedge clk);
    n_checks++; if (req_log.size() != 0) begin n_fail++; $display("FAIL reset_high_release_req: got %0d reqs required 0", req_log.size()); end
    n_checks++; if (mix_cnt != base) begin n_fail++; $display("FAIL reset_high_release_mix: got %0d pulses required 0", mix_cnt - base); end
    sample_clock = 1'b0;
  endtask

  task automatic test_basic();
    bit got;
    int base;
    int act;
    set_all(16'h0100);
    base = mix_cnt;
    run_frame(got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0d required 1", got); end
    n_checks++; if (req_log.size() != NV) begin n_fail++; $display("FAIL basic_req_count: got %0d required %0d", req_log.size(), NV); end
    for (int i = 0; i < NV; i++) begin
      act = (i < req_log.size()) ? req_log[i] : -1;
      n_checks++; if (act != i) begin n_fail++; $display("FAIL basic_req_order[%0d]: got %0d required %0d", i, act, i); end
    end
    n_checks++; if (mix_out !== 16'h0800) begin n_fail++; $display("FAIL basic_mix_out: got %h required 0800", mix_out); end
    n_checks++; if (mix_cyc - tick_cyc != 17) begin n_fail++; $display("FAIL basic_latency: got %0d required 17", mix_cyc - tick_cyc); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b required 0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b required 0", timeout); end
    repeat (6) @(negedge clk);
    n_checks++; if (mix_cnt - base != 1) begin n_fail++; $display("FAIL basic_single_pulse: got %0d required 1", mix_cnt - base); end
    n_checks++; if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b required 0", mix_valid); end
    n_checks++; if (mix_out !== 16'h0800) begin n_fail++; $display("FAIL basic_mix_hold: got %h required 0800", mix_out); end
  endtask

  task automatic test_saturation();
    bit got;
    logic [SW-1:0] vals [5][NV];
    logic [SW-1:0] exp_mix [5];
    for (int i = 0; i < NV; i++) begin
      vals[0][i] = 16'h7000;
      vals[1][i] = 16'h9000;
      vals[2][i] = (i == NV - 1) ? 16'h0FFF : 16'h1000;
      vals[3][i] = 16'hF000;
      vals[4][i] = 16'(i * 3 - 10);
    end
    exp_mix = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0004};
    for (int c = 0; c < 5; c++) begin
      set_all(16'h0000);
      for (int i = 0; i < NV; i++) rsp_val[i] = vals[c][i];
      run_frame(got);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL sat_done[%0d]: got %0d required 1", c, got); end
      n_checks++; if (mix_out !== exp_mix[c]) begin n_fail++; $display("FAIL sat_mix_out[%0d]: got %h required %h", c, mix_out, exp_mix[c]); end
    end
  endtask

  task automatic test_overrun();
    bit got;
    int base;
    set_all(16'h0100);
    rsp_delay[3] = 10;
    base = mix_cnt;
    start_frame();
    repeat (3) @(negedge clk);
    sample_clock = 1'b0;
    repeat (6) @(negedge clk);
    sample_clock = 1'b1;
    wait_mix(400, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL ovr_done: got %0d required 1", got); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    n_checks++; if (mix_out !== 16'h0800) begin n_fail++; $display("FAIL ovr_mix_out: got %h required 0800", mix_out); end
    n_checks++; if (mix_cyc - tick_cyc != 27) begin n_fail++; $display("FAIL ovr_latency: got %0d required 27", mix_cyc - tick_cyc); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ovr_timeout: got %b required 0", timeout); end
    repeat (40) @(negedge clk);
    n_checks++; if (mix_cnt - base != 1) begin n_fail++; $display("FAIL ovr_single_mix: got %0d required 1", mix_cnt - base); end
    n_checks++; if (req_log.size() != NV) begin n_fail++; $display("FAIL ovr_req_count: got %0d required %0d", req_log.size(), NV); end
    pulse_err_clr();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b required 0", overrun); end
    sample_clock = 1'b0;
    // Second overrun lands in the same cycle as err_clr: the set must win.
    start_frame();
    repeat (3) @(negedge clk);
    sample_clock = 1'b0;
    repeat (6) @(negedge clk);
    sample_clock = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_beats_clear: got %b required 1", overrun); end
    wait_mix(400, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL ovr2_done: got %0d required 1", got); end
    pulse_err_clr();
    sample_clock = 1'b0;
  endtask

  task automatic test_timeout();
    bit got;
    set_all(16'h0010);
    rsp_stall[2] = 1'b1;
    run_frame(got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL to_done: got %0d required 1", got); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b required 1", timeout); end
    n_checks++; if (mix_out !== 16'h0070) begin n_fail++; $display("FAIL to_mix_out: got %h required 0070", mix_out); end
    n_checks++; if (mix_cyc - tick_cyc != 32) begin n_fail++; $display("FAIL to_latency: got %0d required 32", mix_cyc - tick_cyc); end
    n_checks++; if (req_log.size() != NV) begin n_fail++; $display("FAIL to_req_count: got %0d required %0d", req_log.size(), NV); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL to_overrun: got %b required 0", overrun); end
    pulse_err_clr();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b required 0", timeout); end
    rsp_stall[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got;
    bit found;
    int base;
    set_all(16'h0100);
    rsp_stall[5] = 1'b1;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (voice_sel == 3'd5 && !voice_req && req_log.size() == 6) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_voice5: got %0d required 1", found); end
    repeat (3) @(negedge clk);
    n_checks++; if (mix_out !== 16'h0070) begin n_fail++; $display("FAIL rmid_pre_mix_out: got %h required 0070", mix_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (voice_sel !== 3'd0) begin n_fail++; $display("FAIL rmid_voice_sel: got %0d required 0", voice_sel); end
    n_checks++; if (voice_req !== 1'b0) begin n_fail++; $display("FAIL rmid_voice_req: got %b required 0", voice_req); end
    n_checks++; if (mix_out !== 16'h0000) begin n_fail++; $display("FAIL rmid_mix_out: got %h required 0000", mix_out); end
    n_checks++; if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_mix_valid: got %b required 0", mix_valid); end
    @(negedge clk);
    rst = 1'b0;
    rsp_stall[5] = 1'b0;
    req_log.delete();
    base = mix_cnt;
    repeat (10) @(negedge clk);
    n_checks++; if (req_log.size() != 0) begin n_fail++; $display("FAIL rmid_no_req: got %0d reqs required 0", req_log.size()); end
    n_checks++; if (mix_cnt != base) begin n_fail++; $display("FAIL rmid_no_mix: got %0d pulses required 0", mix_cnt - base); end
    sample_clock = 1'b0;
    run_frame(got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rmid_resume_done: got %0d required 1", got); end
    n_checks++; if (mix_out !== 16'h0800) begin n_fail++; $display("FAIL rmid_resume_mix: got %h required 0800", mix_out); end
    n_checks++; if (mix_cyc - tick_cyc != 17) begin n_fail++; $display("FAIL rmid_resume_latency: got %0d required 17", mix_cyc - tick_cyc); end
  endtask

`ifdef VOICE_MUTE_EN
  task automatic test_mute();
    bit got;
    int act;
    set_all(16'h0100);
    mute_mask = 8'hAA;
    run_frame(got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mute_done: got %0d required 1", got); end
    n_checks++; if (req_log.size() != 4) begin n_fail++; $display("FAIL mute_req_count: got %0d required 4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      act = (i < req_log.size()) ? req_log[i] : -1;
      n_checks++; if (act != 2 * i) begin n_fail++; $display("FAIL mute_req_order[%0d]: got %0d required %0d", i, act, 2 * i); end
    end
    n_checks++; if (mix_out !== 16'h0400) begin n_fail++; $display("FAIL mute_mix_out: got %h required 0400", mix_out); end
    n_checks++; if (mix_cyc - tick_cyc != 13) begin n_fail++; $display("FAIL mute_latency: got %0d required 13", mix_cyc - tick_cyc); end
    mute_mask = 8'hFF;
    run_frame(got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mute_all_done: got %0d required 1", got); end
    n_checks++; if (mix_out !== 16'h0000) begin n_fail++; $display("FAIL mute_all_mix: got %h required 0000", mix_out); end
    n_checks++; if (req_log.size() != 0) begin n_fail++; $display("FAIL mute_all_reqs: got %0d required 0", req_log.size()); end
    n_checks++; if (mix_cyc - tick_cyc != 9) begin n_fail++; $display("FAIL mute_all_latency: got %0d required 9", mix_cyc - tick_cyc); end
    mute_mask = '0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_all(16'h0000);
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_timeout();
    test_reset_mid();
`ifdef VOICE_MUTE_EN
    test_mute();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_voice_sequencer.md
Name: audio_voice_sequencer

Overview:
Per-sample scheduler for the audio subsystem. It watches the sample_clock square wave from the audio sample-rate divider and, on each rising edge, time-multiplexes one shared voice-synthesis datapath across NUM_VOICES voices using a req/valid handshake. It accumulates the returned voice samples, saturates the sum, and presents one mixed sample per sample period to the audio output stage. Sticky flags report overrun and voice timeout.

Parameters:
NUM_VOICES, 8, number of voices sequenced per sample period (2..16)
VOICE_W, 3, width of voice index; must equal clog2(NUM_VOICES)
SAMPLE_W, 16, signed sample width for voice inputs and mix output
TIMEOUT, 255, max cycles waited for voice_valid before skipping the voice (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_clock  in  1  square wave from the sample-rate divider, synchronous to clk
voice_sel  out  VOICE_W  index of the voice currently being serviced
voice_req  out  1  one-cycle request to the synth datapath for voice_sel
voice_sample  in  SAMPLE_W  signed sample returned by the datapath
voice_valid  in  1  voice_sample is valid; counted only in WAIT
mix_out  out  SAMPLE_W  saturated signed mix; held until the next update
mix_valid  out  1  one-cycle pulse when mix_out updates
overrun  out  1  sticky: a tick arrived while the sequencer was busy
timeout  out  1  sticky: a voice failed to answer within TIMEOUT cycles
err_clr  in  1  clears overrun and timeout

Behaviour:
- Reset (async): state=IDLE; voice_sel, voice_req, mix_out, mix_valid, overrun, timeout, accumulator and wait counter = 0; edge register sc_q = 1, so sample_clock held high through reset release produces no tick.
- Tick = sample_clock & ~sc_q, evaluated at each clk edge; sc_q <= sample_clock every cycle.
- Accumulator: signed, SAMPLE_W+VOICE_W bits. voice_sample is sign-extended before adding. No intermediate overflow is possible.
- FSM:
  - IDLE: on tick, acc=0, voice_sel=0, go to ISSUE.
  - ISSUE: voice_req=1 for exactly this cycle (Moore output), wait counter=0, go to WAIT.
  - WAIT: voice_req=0.
    - On voice_valid: acc += sample.
    - Otherwise, once the counter reaches TIMEOUT-1: voice contributes 0 and timeout is set.
    - Otherwise the counter increments.
    - On advance: if voice_sel==NUM_VOICES-1, go to DONE; else voice_sel++ and go to ISSUE.
  - DONE: mix_out <= clamp(acc, -2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1); mix_valid=1 on the following cycle only; go to IDLE with voice_sel=0.
- voice_valid in IDLE, ISSUE or DONE is ignored. The earliest accepted valid is in the cycle after voice_req.
- Latency: with valid returned the cycle after each req, mix_valid is high 2*NUM_VOICES+1 cycles after the tick edge (17 for NUM_VOICES=8).
- A tick while not in IDLE is dropped and sets overrun; the current sequence completes unaffected.
- err_clr clears both flags. Setting in the same cycle as err_clr wins (the flag stays 1).
- mix_out is unchanged between mix_valid pulses.

Optional Feature:
VOICE_MUTE_EN
- Defined: adds input mute_mask [NUM_VOICES-1:0], latched at the tick.
  - A muted voice spends one cycle in ISSUE with voice_req=0, contributes 0, and advances directly (next voice or DONE).
  - If all voices are muted, the sequencer still emits mix_valid with mix_out=0.
- Undefined: the port is absent and every voice is requested.

Test Plan:
- NUM_VOICES=8; responder returns 0x0100 one cycle after each req -> eight reqs with voice_sel 0..7; mix_out=0x0800; mix_valid 17 cycles after tick; overrun=timeout=0.
- All voices return 0x7000 -> mix_out=0x7FFF. All voices return 0x9000 -> mix_out=0x8000.
- Responder stalls voice 3 while a second sample_clock rise occurs -> overrun=1; mix completes with the correct sum; only one mix_valid. Then err_clr=1 -> overrun=0. err_clr held during a second overrun -> overrun=1.
- TIMEOUT=16; voice 2 never responds, others return 0x0010 -> voice 2 released after 16 WAIT cycles; timeout=1; mix_out=0x0070.
- Assert rst mid-WAIT on voice 5 with sample_clock high, release while still high -> all outputs 0 immediately, no mix_valid, no req until the next 0->1 of sample_clock.
- VOICE_MUTE_EN, mute_mask=0xAA, all voices 0x0100 -> reqs only for voices 0,2,4,6; mix_out=0x0400; mix_valid 13 cycles after tick.
